// File: rtl/exc_ctrl.sv
// Exception control unit for the single-cycle LEGv8 core: latches ELR/ESR, redirects the PC to
// the exception vector or back to ELR, and owns the external-interrupt pending latch.
module exc_ctrl #(
  parameter int unsigned    N      = 64,
  parameter logic [N-1:0]   VECTOR = {{(N-8){1'b0}}, 8'hD8}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_req,
  input  logic             instr_valid,
  input  logic [N-1:0]     pc_cur,
  input  logic             Exc,
  input  logic [3:0]       EStatus,
  input  logic             ERet,
  input  logic             NotAnInstr,
  input  logic [1:0]       sysreg_sel,
  output logic             ExtIRQ,
  output logic             redirect,
  output logic [N-1:0]     redirect_pc,
  output logic             flush,
  output logic             irq_ack,
  output logic             in_handler,
  output logic             halted,
  output logic [N-1:0]     sysreg_rdata
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StTake    = 3'd1,
    StHandler = 3'd2,
    StReturn  = 3'd3,
    StHalt    = 3'd4
  } state_e;

  state_e       state_q;
  logic [N-1:0] elr_q;
  logic [3:0]   esr_q;
  logic [7:0]   count_q;
  logic         irq_pending_q;
  logic         take_irq;

  assign take_irq = (state_q == StIdle) && instr_valid && Exc && (EStatus == 4'b0001);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      elr_q         <= '0;
      esr_q         <= '0;
      count_q       <= '0;
      irq_pending_q <= 1'b0;
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      irq_ack       <= 1'b0;
      in_handler    <= 1'b0;
      halted        <= 1'b0;
    end else begin
      // Pulse outputs default low; in_handler/halted hold until a transition changes them.
      redirect    <= 1'b0;
      redirect_pc <= '0;
      irq_ack     <= 1'b0;
      // A fresh request wins over the clear so a re-raise stays pending.
      irq_pending_q <= irq_req | (irq_pending_q & ~take_irq);
      unique case (state_q)
        StIdle: begin
          if (instr_valid && Exc) begin
            state_q     <= StTake;
            elr_q       <= pc_cur;
            esr_q       <= EStatus;
            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
            redirect    <= 1'b1;
            redirect_pc <= VECTOR;
            irq_ack     <= (EStatus == 4'b0001);
            in_handler  <= 1'b1;
          end
        end
        StTake: state_q <= StHandler;
        StHandler: begin
          if (instr_valid && NotAnInstr) begin
            state_q    <= StHalt;
            in_handler <= 1'b0;
            halted     <= 1'b1;
          end else if (instr_valid && ERet) begin
            state_q     <= StReturn;
            in_handler  <= 1'b0;
            redirect    <= 1'b1;
            redirect_pc <= elr_q;
          end
        end
        StReturn: state_q <= StIdle;
        StHalt:   state_q <= StHalt;
        default:  state_q <= StHalt;
      endcase
    end
  end

  assign flush  = redirect;
  assign ExtIRQ = irq_pending_q && (state_q == StIdle);

  // Halted core drives every output except halted to zero, MRS data included.
  always_comb begin
    sysreg_rdata = '0;
    if (state_q != StHalt) begin
      unique case (sysreg_sel)
        2'b00:   sysreg_rdata = elr_q;
        2'b01:   sysreg_rdata = {{(N-4){1'b0}}, esr_q};
        2'b10:   sysreg_rdata = {{(N-11){1'b0}}, state_q, count_q};
        default: sysreg_rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception control unit for the single-cycle LEGv8 core. Sits directly downstream of the main decoder: consumes its `Exc`, `EStatus`, `ERet` and `NotAnInstr` outputs, latches the exception system registers (ELR, ESR), and redirects the PC to the exception vector or back to ELR. It also owns the external-interrupt pending latch and drives the masked `ExtIRQ` back into the decoder.

## Interface

Parameters:

- `N`, 64, datapath/PC width.
- `VECTOR`, 64'h0000_0000_0000_00D8, exception handler entry address.

Ports:

- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-low (0 = reset), single clock domain.
- `irq_req`  in  1  external interrupt request, level.
- `instr_valid`  in  1  current instruction is real (not a flushed bubble).
- `pc_cur`  in  N  PC of the instruction being decoded.
- `Exc`  in  1  exception request from the decoder.
- `EStatus`  in  4  cause from the decoder: 0001 IRQ, 0010 invalid opcode.
- `ERet`  in  1  ERET decoded.
- `NotAnInstr`  in  1  invalid opcode decoded.
- `sysreg_sel`  in  2  MRS source: 00 ELR, 01 ESR, 10 {state, exc_count}, 11 zero.
- `ExtIRQ`  out  1  masked interrupt to the decoder.
- `redirect`  out  1  PC mux override, one-cycle pulse.
- `redirect_pc`  out  N  target when `redirect`=1.
- `flush`  out  1  kill current instruction's writeback/memory; equals `redirect`.
- `irq_ack`  out  1  one-cycle pulse when an IRQ exception is taken.
- `in_handler`  out  1  1 in states TAKE and HANDLER.
- `halted`  out  1  double fault; core must stop.
- `sysreg_rdata`  out  N  MRS read data, combinational on `sysreg_sel`.

## Operation

- States: IDLE, TAKE, HANDLER, RETURN, HALT. Encoded 3 bits; `state` is readable through `sysreg_sel`=10 as bits [10:8], `exc_count` as bits [7:0].
- `irq_pending`: set on any edge with `irq_req`=1; cleared only at the edge entering TAKE with cause IRQ. Set has priority when both happen (re-raise stays pending).
- `ExtIRQ` = `irq_pending` & (state==IDLE).
- IDLE: at edge with `instr_valid`&`Exc` -> ELR<=`pc_cur`, ESR<={N-4 zeros, `EStatus`}, `exc_count`+=1 (saturates at 255), -> TAKE. `ERet` in IDLE is ignored (no redirect, no state change). `Exc` and `ERet` both set: `Exc` wins.
- TAKE: `redirect`=1, `redirect_pc`=`VECTOR`, `irq_ack`=(ESR[3:0]==0001). -> HANDLER unconditionally.
- HANDLER: IRQ masked. At edge with `instr_valid`&`NotAnInstr` -> HALT (ELR/ESR unchanged). Else at edge with `instr_valid`&`ERet` -> RETURN. `instr_valid`=0 suppresses all transitions.
- RETURN: `redirect`=1, `redirect_pc`=ELR. -> IDLE.
- HALT: `halted`=1, all other outputs 0; exits only via reset.
- The faulting instruction is never re-executed by this block: ELR is the faulting PC, and the handler adjusts ELR by software convention.

## Timing

- Reset (`reset`=0 at an edge): state=IDLE, ELR=0, ESR=0, `exc_count`=0, `irq_pending`=0. All outputs 0 in the following cycle; `sysreg_rdata` reflects the cleared registers.
- Exception latency: `Exc` sampled at edge k; `redirect`/`flush` are high for exactly cycle k+1. The instruction fetched at `VECTOR` executes in cycle k+2.
- Return latency is identical: `ERet` at edge k gives the redirect to ELR in cycle k+1.
- `irq_req` rising in cycle k: `ExtIRQ`=1 in cycle k+1 (if IDLE). The decoder's `Exc` then follows combinationally.
- Reset asserted in any state, including TAKE or RETURN mid-pulse, aborts the redirect at that edge.
- `sysreg_rdata` is combinational; an MRS in the cycle of a register update reads the old value.

## Test plan

- Reset then idle: hold `reset`=0 for 2 cycles, release -> all outputs 0, `sysreg_rdata`(sel 00)=0.
- Invalid opcode: `pc_cur`=0x40, `Exc`=1, `EStatus`=0010 for one cycle -> next cycle `redirect`=1, `redirect_pc`=0xD8, `irq_ack`=0; then `in_handler`=1; sel 00 reads 0x40, sel 01 reads 0x2.
- IRQ round trip: pulse `irq_req` -> `ExtIRQ`=1; drive `Exc`=1, `EStatus`=0001 at `pc_cur`=0x100 -> `irq_ack` pulse and `ExtIRQ`=0 while in the handler; `ERet`=1 -> `redirect_pc`=0x100 for one cycle, then IDLE.
- Masking: `irq_req` held high during HANDLER -> `ExtIRQ` stays 0; it goes to 1 the cycle after RETURN.
- Double fault: in HANDLER, `NotAnInstr`=1 with `instr_valid`=1 -> `halted`=1 and stays 1 through 10 cycles of `ERet`/`Exc`; `reset`=0 clears it.
- Bubble, priority and saturation cases:
  - `Exc`=1 with `instr_valid`=0 -> no transition.
  - `Exc`=`ERet`=1 in IDLE -> TAKE.
  - 256 exceptions -> `exc_count` stays at 255.
